// File: rtl/jvm_useq.sv
// Micro-sequencer: walks the next-address ROM chain for one JVM opcode; optional USEQ_WDOG_EN adds a step watchdog.
// First step 1 cycle after opcode accept, one step per accepted cycle; stalls hold upc and block new opcodes.
module jvm_useq #(
    parameter int ADDR_W     = 9,
    parameter int OPC_W      = 8,
    parameter int WDOG_LIMIT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [OPC_W-1:0]  op_data,
    output logic              op_ready,
    output logic [ADDR_W-1:0] upc,
    input  logic [ADDR_W-1:0] nxt_adr,
    output logic              uop_valid,
    input  logic              uop_ready,
    input  logic              flush,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_ERR  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   upc_q, upc_d;
    logic                err_q, err_d;
    logic                op_take;
    logic                step_take;
    logic                wdog_trip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            upc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        upc_d     = upc_q;
        err_d     = err_q;
        op_ready  = 1'b0;
        uop_valid = 1'b0;
        op_take   = 1'b0;
        step_take = 1'b0;
        case (state_q)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    upc_d   = ADDR_W'(op_data);
                    state_d = S_RUN;
                    op_take = 1'b1;
                end
            end
            S_RUN: begin
                uop_valid = 1'b1;
                if (uop_ready) begin
                    step_take = 1'b1;
                    if (nxt_adr == '0) begin
                        // Last step: take the next opcode in the same cycle for zero-bubble chaining.
                        op_ready = 1'b1;
                        if (op_valid) begin
                            upc_d   = ADDR_W'(op_data);
                            op_take = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else if ((nxt_adr == '1) || wdog_trip) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        upc_d = nxt_adr;
                    end
                end
            end
            S_ERR: begin
                err_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Refusing opcodes during flush keeps fetch from losing one it thinks was taken.
        if (flush) begin
            state_d  = S_IDLE;
            upc_d    = '0;
            err_d    = 1'b0;
            op_ready = 1'b0;
            op_take  = 1'b0;
        end
    end

`ifdef USEQ_WDOG_EN
    localparam int CNT_W = $clog2(WDOG_LIMIT) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (flush || op_take) begin
            cnt_d = '0;
        end else if (step_take) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // The step being accepted now is number cnt_q+1; a non-final step WDOG_LIMIT traps.
    assign wdog_trip = (cnt_q == CNT_W'(WDOG_LIMIT - 1));
`else
    logic unused_wdog;

    assign unused_wdog = op_take ^ step_take ^ (WDOG_LIMIT == 0);
    assign wdog_trip   = 1'b0;
`endif

    assign upc  = upc_q;
    assign err  = err_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_jvm_useq.sv
// Bench for jvm_useq: directed scenarios plus randomized opcode/stall traffic against a chain-walking scoreboard.
module tb_jvm_useq;

    logic       clk;
    logic       rst;
    logic       op_valid;
    logic [7:0] op_data;
    logic       op_ready;
    logic [8:0] upc;
    logic [8:0] nxt_adr;
    logic       uop_valid;
    logic       uop_ready;
    logic       flush;
    logic       busy;
    logic       err;

    logic [8:0] rom [512];
    int         total;
    int         bad;
    int         exp_q[$];

    jvm_useq #(.ADDR_W(9), .OPC_W(8), .WDOG_LIMIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_data   (op_data),
        .op_ready  (op_ready),
        .upc       (upc),
        .nxt_adr   (nxt_adr),
        .uop_valid (uop_valid),
        .uop_ready (uop_ready),
        .flush     (flush),
        .busy      (busy),
        .err       (err)
    );

    assign nxt_adr = rom[upc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // exp_upc < 0 skips the upc comparison where its value is don't-care.
    task automatic cyc(input string tag, input int exp_upc, input logic exp_v, input logic exp_r);
        @(negedge clk);
        if (exp_upc >= 0) chk({tag, "_upc"}, 32'(upc), exp_upc);
        chk({tag, "_vld"}, 32'(uop_valid), 32'(exp_v));
        chk({tag, "_ordy"}, 32'(op_ready), 32'(exp_r));
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 512; i++) rom[i] = 9'h000;
    endtask

    // Reference: an opcode yields itself followed by every nonzero ROM link until 0.
    task automatic expand(input logic [7:0] op);
        logic [8:0] a;
        a = {1'b0, op};
        exp_q.push_back(int'(a));
        a = rom[a];
        for (int k = 0; k < 16 && a != 9'h000; k++) begin
            exp_q.push_back(int'(a));
            a = rom[a];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] op_tab [16];
        logic [8:0] prev;
        logic [8:0] next_free;
        logic       acc_op;
        logic       draining;
        int         len;

        total = 0;
        bad = 0;
        clear_rom();
        rst = 1'b1;
        op_valid = 1'b0;
        op_data = 8'h00;
        uop_ready = 1'b0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_upc", 32'(upc), 0);
        chk("rst_vld", 32'(uop_valid), 0);
        chk("rst_ordy", 32'(op_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        @(posedge clk);
        #1;

        // 0x59 -> 0x100 -> 0x101 -> end
        rom[9'h059] = 9'h100; rom[9'h100] = 9'h101; rom[9'h101] = 9'h000;
        op_valid = 1'b1; op_data = 8'h59; uop_ready = 1'b1;
        cyc("t1_idle", 0, 1'b0, 1'b1);
        op_valid = 1'b0;
        cyc("t1_s0", 'h059, 1'b1, 1'b0);
        cyc("t1_s1", 'h100, 1'b1, 1'b0);
        cyc("t1_s2", 'h101, 1'b1, 1'b1);
        cyc("t1_end", -1, 1'b0, 1'b1);
        chk("t1_busy", 32'(busy), 0);

        // single-step 0x00 chained straight into 0x5C
        rom[9'h05C] = 9'h102; rom[9'h102] = 9'h103; rom[9'h103] = 9'h000;
        op_valid = 1'b1; op_data = 8'h00;
        cyc("t2_idle", -1, 1'b0, 1'b1);
        op_data = 8'h5C;
        cyc("t2_s0", 'h000, 1'b1, 1'b1);
        op_valid = 1'b0;
        cyc("t2_s1", 'h05C, 1'b1, 1'b0);
        cyc("t2_s2", 'h102, 1'b1, 1'b0);
        cyc("t2_s3", 'h103, 1'b1, 1'b1);
        cyc("t2_end", -1, 1'b0, 1'b1);

        // stall on 0x10C
        rom[9'h095] = 9'h10C; rom[9'h10C] = 9'h000;
        op_valid = 1'b1; op_data = 8'h95;
        cyc("t3_idle", -1, 1'b0, 1'b1);
        op_valid = 1'b0;
        cyc("t3_s0", 'h095, 1'b1, 1'b0);
        uop_ready = 1'b0;
        op_valid = 1'b1; op_data = 8'h00;
        for (int i = 0; i < 3; i++) cyc("t3_stall", 'h10C, 1'b1, 1'b0);
        op_valid = 1'b0;
        uop_ready = 1'b1;
        cyc("t3_rel", 'h10C, 1'b1, 1'b1);
        cyc("t3_end", -1, 1'b0, 1'b1);

        // illegal link at 0x101 then flush
        rom[9'h101] = 9'h1FF;
        op_valid = 1'b1; op_data = 8'h59;
        cyc("t4_idle", -1, 1'b0, 1'b1);
        op_valid = 1'b0;
        cyc("t4_s0", 'h059, 1'b1, 1'b0);
        cyc("t4_s1", 'h100, 1'b1, 1'b0);
        cyc("t4_s2", 'h101, 1'b1, 1'b0);
        cyc("t4_err", 'h101, 1'b0, 1'b0);
        chk("t4_errf", 32'(err), 1);
        chk("t4_busy", 32'(busy), 1);
        flush = 1'b1;
        cyc("t4_fl", 'h101, 1'b0, 1'b0);
        flush = 1'b0;
        cyc("t4_post", 0, 1'b0, 1'b1);
        chk("t4_errclr", 32'(err), 0);
        chk("t4_busyclr", 32'(busy), 0);

        // asynchronous reset in the middle of step 0x100
        rom[9'h101] = 9'h000;
        op_valid = 1'b1; op_data = 8'h59;
        cyc("t5_idle", 0, 1'b0, 1'b1);
        op_valid = 1'b0;
        cyc("t5_s0", 'h059, 1'b1, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_upc", 32'(upc), 0);
        chk("t5_rst_vld", 32'(uop_valid), 0);
        chk("t5_rst_ordy", 32'(op_ready), 1);
        chk("t5_rst_busy", 32'(busy), 0);
        #1 rst = 1'b0;
        op_valid = 1'b1; op_data = 8'h00;
        cyc("t5_idle2", 0, 1'b0, 1'b1);
        op_valid = 1'b0;
        cyc("t5_one", 'h000, 1'b1, 1'b1);
        cyc("t5_end", -1, 1'b0, 1'b1);

`ifdef USEQ_WDOG_EN
        // endless 0x100 <-> 0x101 loop caught after 4 steps
        rom[9'h010] = 9'h100; rom[9'h100] = 9'h101; rom[9'h101] = 9'h100;
        op_valid = 1'b1; op_data = 8'h10;
        cyc("t6_idle", -1, 1'b0, 1'b1);
        op_valid = 1'b0;
        cyc("t6_s0", 'h010, 1'b1, 1'b0);
        cyc("t6_s1", 'h100, 1'b1, 1'b0);
        cyc("t6_s2", 'h101, 1'b1, 1'b0);
        cyc("t6_s3", 'h100, 1'b1, 1'b0);
        cyc("t6_err", -1, 1'b0, 1'b0);
        chk("t6_errf", 32'(err), 1);
        flush = 1'b1;
        cyc("t6_fl", -1, 1'b0, 1'b0);
        flush = 1'b0;
        chk("t6_errclr", 32'(err), 0);
`endif

        // random chains of 1..4 steps on 16 opcodes
        clear_rom();
        next_free = 9'h110;
        for (int i = 0; i < 16; i++) begin
            op_tab[i] = 8'($urandom_range(0, 255));
            len = $urandom_range(0, 3);
            prev = {1'b0, op_tab[i]};
            for (int k = 0; k < len; k++) begin
                rom[prev] = next_free;
                prev = next_free;
                next_free = next_free + 9'd1;
            end
            rom[prev] = 9'h000;
        end

        acc_op = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 1000; c++) begin
            draining = (c >= 970);
            if (draining) begin
                op_valid = 1'b0;
                uop_ready = 1'b1;
            end else begin
                if (!op_valid || acc_op) begin
                    op_valid = ($urandom_range(0, 2) != 0);
                    op_data = op_tab[$urandom_range(0, 15)];
                end
                uop_ready = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            chk("r_vld", 32'(uop_valid), 32'(exp_q.size() != 0));
            chk("r_busy", 32'(busy), 32'(exp_q.size() != 0));
            chk("r_ordy", 32'(op_ready),
                32'((exp_q.size() == 0) || (exp_q.size() == 1 && uop_ready)));
            acc_op = op_valid && op_ready;
            if (uop_valid && uop_ready && exp_q.size() != 0) begin
                chk("r_upc", 32'(upc), exp_q.pop_front());
            end
            if (acc_op) expand(op_data);
            @(posedge clk);
            #1;
        end
        chk("r_drained", 32'(exp_q.size()), 0);
        chk("r_err", 32'(err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
